// File: rtl/key_rpt_pkg.sv
// Shared console timing package: key FSM states, default timing and helpers.
package key_rpt_pkg;

    localparam int unsigned DEB_DEF        = 100;
    localparam int unsigned RPT_FIRST_DEF  = 4000;
    localparam int unsigned RPT_PERIOD_DEF = 1000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DEB_ON  = 2'd1,
        ST_HELD    = 2'd2,
        ST_DEB_OFF = 2'd3
    } key_st_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous console inputs.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_rpt.sv
// Console key debouncer with press pulse and auto-repeat while the key is held.
module key_rpt
    import key_rpt_pkg::*;
#(
    parameter int unsigned DEB        = DEB_DEF,
    parameter int unsigned RPT_FIRST  = RPT_FIRST_DEF,
    parameter int unsigned RPT_PERIOD = RPT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    input  logic rpt_en,
    output logic key_lvl,
    output logic key_p,
    output logic rpt_p,
    output logic busy
);

    // Zero-length intervals are clamped to one cycle.
    localparam int unsigned DEB_E = max_u(DEB, 1);
    localparam int unsigned RF_E  = max_u(RPT_FIRST, 1);
    localparam int unsigned RP_E  = max_u(RPT_PERIOD, 1);
    localparam int unsigned CW    = $clog2(max_u(max_u(DEB_E, RF_E), RP_E)) + 1;

    localparam logic [CW-1:0] DEB_C = CW'(DEB_E);
    localparam logic [CW-1:0] RF_C  = CW'(RF_E);
    localparam logic [CW-1:0] RP_C  = CW'(RP_E);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [CW-1:0] MAX_C = '1;

    logic          key_s;
    key_st_e       state_q, state_d;
    logic [CW-1:0] deb_q, deb_d;
    logic [CW-1:0] rpt_q, rpt_d;
    logic [CW-1:0] rpt_thr;
    logic          rep_q, rep_d;
    logic          key_lvl_d, key_p_d, rpt_p_d, busy_d;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (key),
        .q     (key_s)
    );

    // Next-state, counters and registered-output inputs.
    always_comb begin
        state_d = state_q;
        deb_d   = deb_q;
        rpt_d   = rpt_q;
        rep_d   = rep_q;
        key_p_d = 1'b0;
        rpt_p_d = 1'b0;
        rpt_thr = rep_q ? RP_C : RF_C;

        case (state_q)
            ST_IDLE: begin
                deb_d = '0;
                if (key_s) begin
                    state_d = ST_DEB_ON;
                    deb_d   = ONE_C;
                end
            end
            ST_DEB_ON: begin
                if (!key_s) begin
                    state_d = ST_IDLE;
                    deb_d   = '0;
                end else if (deb_q >= DEB_C) begin
                    state_d = ST_HELD;
                    deb_d   = '0;
                    key_p_d = 1'b1;
                end else if (deb_q != MAX_C) begin
                    deb_d = deb_q + ONE_C;
                end
            end
            ST_HELD: begin
                deb_d = '0;
                if (!key_s) begin
                    state_d = ST_DEB_OFF;
                    deb_d   = ONE_C;
                end
            end
            ST_DEB_OFF: begin
                if (key_s) begin
                    state_d = ST_HELD;
                    deb_d   = '0;
                end else if (deb_q >= DEB_C) begin
                    state_d = ST_IDLE;
                    deb_d   = '0;
                end else if (deb_q != MAX_C) begin
                    deb_d = deb_q + ONE_C;
                end
            end
            default: begin
                state_d = ST_IDLE;
                deb_d   = '0;
            end
        endcase

        // Repeat timer advances only in HELD; DEB_OFF freezes it so a glitch just delays the cadence.
        if (!rpt_en || state_q == ST_IDLE || state_q == ST_DEB_ON) begin
            rpt_d = '0;
            rep_d = 1'b0;
        end else if (state_q == ST_HELD) begin
            if (rpt_q >= rpt_thr - ONE_C) begin
                rpt_p_d = 1'b1;
                rpt_d   = '0;
                rep_d   = 1'b1;
            end else if (rpt_q != MAX_C) begin
                rpt_d = rpt_q + ONE_C;
            end
        end

        key_lvl_d = (state_d == ST_HELD) || (state_d == ST_DEB_OFF);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            deb_q   <= '0;
            rpt_q   <= '0;
            rep_q   <= 1'b0;
            key_lvl <= 1'b0;
            key_p   <= 1'b0;
            rpt_p   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            rpt_q   <= rpt_d;
            rep_q   <= rep_d;
            key_lvl <= key_lvl_d;
            key_p   <= key_p_d;
            rpt_p   <= rpt_p_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: tb/tb_key_rpt.sv
// Bench for key_rpt: hand vectors, scripted corner sequences and randomized run against a reference model.
module tb_key_rpt;

    localparam int unsigned DEB = 4;
    localparam int unsigned RF  = 10;
    localparam int unsigned RP  = 5;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic key    = 1'b0;
    logic rpt_en = 1'b0;
    logic key_lvl, key_p, rpt_p, busy;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    // Reference model: key_s delay line, accepted level, pending opposite-run length, enabled hold time.
    bit m_s1, m_s2, m_lvl, m_kp, m_rp, m_busy;
    int m_run, m_t;

    logic [63:0] kp_h, rp_h, lvl_h, busy_h;

    typedef struct {
        logic       k;
        logic       en;
        logic       rst;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[17];

    always #5 clk = ~clk;

    key_rpt #(.DEB(DEB), .RPT_FIRST(RF), .RPT_PERIOD(RP)) dut (
        .clk     (clk),
        .reset   (reset),
        .key     (key),
        .rpt_en  (rpt_en),
        .key_lvl (key_lvl),
        .key_p   (key_p),
        .rpt_p   (rpt_p),
        .busy    (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic model_edge(input bit k, input bit en, input bit rst);
        bit ks, held;
        if (!rst) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_t = 0;
            m_kp = 0; m_rp = 0; m_busy = 0;
            return;
        end
        ks   = m_s2;
        held = m_lvl && (m_run == 0);
        m_kp = 0;
        m_rp = 0;
        if (!en || !m_lvl) m_t = 0;
        else if (held) begin
            m_t++;
            if (m_t >= RF && ((m_t - RF) % RP) == 0) m_rp = 1;
        end
        if (ks != m_lvl) begin
            m_run++;
            if (m_run > DEB) begin
                m_lvl = !m_lvl;
                m_run = 0;
                m_kp  = m_lvl;
            end
        end else begin
            m_run = 0;
        end
        m_s2   = m_s1;
        m_s1   = k;
        m_busy = m_lvl || (m_run > 0);
    endtask

    task automatic step(input logic k, input logic en, input logic rst);
        key = k; rpt_en = en; reset = rst;
        @(posedge clk);
        model_edge(k, en, rst);
        #1;
        check($sformatf("model cyc %0d", cyc), {28'd0, key_lvl, key_p, rpt_p, busy},
              {28'd0, m_lvl, m_kp, m_rp, m_busy});
        if (cyc < 64) begin
            kp_h[cyc] = key_p; rp_h[cyc] = rpt_p; lvl_h[cyc] = key_lvl; busy_h[cyc] = busy;
        end
        cyc++;
    endtask

    task automatic start_scn();
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        kp_h = '0; rp_h = '0; lvl_h = '0; busy_h = '0;
        cyc = 0;
    endtask

    function automatic int ones(input logic [63:0] h, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (h[i] === 1'b1) n++;
        return n;
    endfunction

    initial begin
        int len, kv, env;

        // Clean press/release, rpt_en low; exp = {key_lvl, key_p, rpt_p, busy}.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'b0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 4'b0000};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 4'b0000};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 4'b0001};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 4'b0001};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 4'b0001};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 4'b0001};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 4'b1101};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 4'b1001};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'b1001};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 4'b1001};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 4'b1001};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 4'b1001};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 4'b1001};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 4'b1001};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 4'b0000};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 4'b0000};
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].k, tbl[i].en, tbl[i].rst);
            check($sformatf("vec %0d", i), {28'd0, key_lvl, key_p, rpt_p, busy}, {28'd0, tbl[i].exp});
        end

        // Clean press held 40 cycles, repeat disabled.
        start_scn();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b1);
        check("clean kp@6", kp_h[6], 1);
        check("clean kp count", ones(kp_h, 0, 39), 1);
        check("clean lvl@5", lvl_h[5], 0);
        check("clean lvl 6..39", ones(lvl_h, 6, 39), 34);
        check("clean no rpt", ones(rp_h, 0, 39), 0);

        // Bouncing press: high 2, low 1, high 2, low 1, then steady.
        start_scn();
        for (int i = 0; i < 24; i++) step((i == 2 || i == 5) ? 1'b0 : 1'b1, 1'b0, 1'b1);
        check("bounce kp count", ones(kp_h, 0, 23), 1);
        check("bounce kp@12", kp_h[12], 1);

        // Auto-repeat, rpt_en dropped at cycle 23.
        start_scn();
        for (int i = 0; i < 40; i++) step(1'b1, (i < 23) ? 1'b1 : 1'b0, 1'b1);
        check("rpt kp@6", kp_h[6], 1);
        check("rpt @16", rp_h[16], 1);
        check("rpt @21", rp_h[21], 1);
        check("rpt none@26", rp_h[26], 0);
        check("rpt count", ones(rp_h, 0, 39), 2);

        // Release glitch of two cycles while held.
        start_scn();
        for (int i = 0; i < 32; i++) step((i == 12 || i == 13) ? 1'b0 : 1'b1, 1'b1, 1'b1);
        check("glitch kp count", ones(kp_h, 0, 31), 1);
        check("glitch lvl held", ones(lvl_h, 6, 31), 26);
        check("glitch none@16", rp_h[16], 0);
        check("glitch rpt@18", rp_h[18], 1);
        check("glitch rpt@23", rp_h[23], 1);
        check("glitch rpt@28", rp_h[28], 1);

        // Reset mid-held, released with key still high.
        start_scn();
        for (int i = 0; i < 28; i++) step(1'b1, 1'b0, (i == 12 || i == 13) ? 1'b0 : 1'b1);
        check("rst lvl@11", lvl_h[11], 1);
        check("rst outs@12", {lvl_h[12], kp_h[12], rp_h[12], busy_h[12]}, 0);
        check("rst outs@13", {lvl_h[13], kp_h[13], rp_h[13], busy_h[13]}, 0);
        check("rst lvl@19", lvl_h[19], 0);
        check("rst kp@20", kp_h[20], 1);
        check("rst kp count", ones(kp_h, 0, 27), 2);

        // Randomized key runs, occasional rpt_en toggles and resets.
        start_scn();
        kv = 0; env = 1; len = 0;
        for (int i = 0; i < 4000; i++) begin
            if (len == 0) begin
                kv  = 1 - kv;
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(5, 40);
            end
            len--;
            if ($urandom_range(0, 199) == 0) env = 1 - env;
            step(kv[0], env[0], ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/key_rpt.md
KEY_RPT -- requirements
Module: key_rpt

Interface
REQ-001 Parameter DEB, default 100: number of consecutive synchronized samples needed to accept a key level change.
REQ-002 Parameter RPT_FIRST, default 4000: cycles from the press pulse to the first repeat pulse.
REQ-003 Parameter RPT_PERIOD, default 1000: cycles between later repeat pulses.
REQ-004 Port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: reset is synchronous and active-low.
REQ-006 Port key, input, 1: raw asynchronous console switch, bouncing.
REQ-007 Port rpt_en, input, 1: enables repeat pulses while the key is held (console REPEAT switch).
REQ-008 Port key_lvl, output, 1: debounced key level; feeds a downstream pg level input.
REQ-009 Port key_p, output, 1: one-cycle pulse on each accepted press.
REQ-010 Port rpt_p, output, 1: one-cycle repeat pulse.
REQ-011 Port busy, output, 1: high in every state except IDLE.

Function
REQ-012 key SHALL pass a 2-flop synchronizer; only the synchronized signal key_s is used downstream.
REQ-013 FSM states SHALL be IDLE, DEB_ON, HELD and DEB_OFF.
REQ-014 IDLE -> DEB_ON SHALL occur when key_s=1; the debounce counter loads 1.
REQ-015 In DEB_ON, key_s=0 SHALL return to IDLE and clear the counter; reaching DEB consecutive highs SHALL enter HELD.
REQ-016 On entry to HELD, key_lvl SHALL rise and key_p SHALL assert for exactly one cycle; press latency is DEB+2 cycles from the first clock edge that samples key high, with no bounce.
REQ-017 HELD -> DEB_OFF SHALL occur when key_s=0.
REQ-018 In DEB_OFF, key_s=1 SHALL return to HELD with no new key_p; DEB consecutive lows SHALL enter IDLE and drop key_lvl in that same cycle.
REQ-019 key_lvl SHALL be 1 in HELD and DEB_OFF and 0 otherwise.
REQ-020 Repeat counter in HELD with rpt_en=1:
- rpt_p SHALL assert RPT_FIRST cycles after key_p.
- rpt_p SHALL then assert every RPT_PERIOD cycles.
REQ-021 The repeat counter SHALL hold its value in DEB_OFF, resume on return to HELD, and clear on entry to IDLE.
REQ-022 rpt_en=0 SHALL clear the repeat counter and suppress rpt_p; re-enabling while held SHALL restart the RPT_FIRST interval.
REQ-023 key_p and rpt_p SHALL never assert in the same cycle; if RPT_FIRST=0, it is treated as 1.
REQ-024 Counter widths SHALL be clog2 of the largest parameter plus 1; counters saturate and never wrap.

Reset
REQ-025 On reset=0 at a clock edge, the block SHALL enter IDLE and clear the synchronizer and all counters.
REQ-026 During reset, key_lvl, key_p, rpt_p and busy SHALL all be 0.
REQ-027 Reset asserted mid-HELD SHALL drop key_lvl on the next edge with no trailing pulse.
REQ-028 After reset releases with key already held, the block SHALL produce a fresh key_p after the full press latency.

Structure
REQ-029 The state encoding and the default timing parameters SHALL live in the shared timing package, next to the delay-line constants.
REQ-030 The synchronizer SHALL be a sub-module named sync2, reusable by other console inputs.

Verification (DEB=4, RPT_FIRST=10, RPT_PERIOD=5)
REQ-031 Clean press at edge 0, held for 40 cycles, rpt_en=0 -> key_p at cycle 6, key_lvl high from cycle 6, no rpt_p.
REQ-032 Bouncing press (high 2, low 1, high 2, low 1, then steady high) -> exactly one key_p, 4 cycles after key_s settles high.
REQ-033 Held with rpt_en=1 -> key_p at cycle 6, rpt_p at cycles 16, 21, 26, ...; rpt_en dropped at cycle 23 -> no rpt_p at 26.
REQ-034 Release glitch (key low 2 cycles while held) -> no key_lvl drop, no new key_p, repeat cadence delayed by 2 cycles.
REQ-035 reset=0 at cycle 12 while held -> all outputs 0 at cycle 13; reset released with key high -> key_p 6 cycles later.
